// File: rtl/hs4_tx_m.sv
// Clock-domain transmitter for a four-phase bundled-data req/ack channel.
// Holds data stable, enforces data-before-req setup, synchronizes ack and flags stalls.
module hs4_tx_m #(
   parameter int WIDTH          = 32,
   parameter int SETUP_CYCLES   = 1,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             a_req,
   output logic [WIDTH-1:0] a_data,
   input  logic             a_ack,
   output logic             busy,
   output logic             timeout_err,
   input  logic             err_clr
);

   localparam int MAX_CNT = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = (MAX_CNT < 32'sd1) ? 32'sd1 : $clog2(MAX_CNT + 32'sd1);

   localparam logic [CW-1:0] SETUP_V   = CW'(SETUP_CYCLES);
   localparam logic [CW-1:0] TO_LAST_V = (TIMEOUT_CYCLES > 32'sd0) ? CW'(TIMEOUT_CYCLES - 32'sd1) : '0;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic          TO_EN     = (TIMEOUT_CYCLES != 32'sd0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      REQ_HI = 2'd2,
      REQ_LO = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 state_s;
   logic                   a_req_r;
   logic                   a_req_s;
   logic [WIDTH-1:0]       a_data_r;
   logic [WIDTH-1:0]       a_data_s;
   logic [CW-1:0]          cnt_r;
   logic [CW-1:0]          cnt_s;
   logic [CW-1:0]          wcnt_r;
   logic [CW-1:0]          wcnt_s;
   logic                   err_r;
   logic                   err_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   ack_sync_s;
   logic                   wait_s;
   logic                   enter_s;
   logic                   set_s;

   // Saturating increment so a long stall never wraps the wait counter.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   assign ack_sync_s  = sync_r[SYNC_STAGES-1];
   assign s_ready     = (state_r == IDLE);
   assign busy        = (state_r != IDLE);
   assign a_req       = a_req_r;
   assign a_data      = a_data_r;
   assign timeout_err = err_r;

   // Ack synchronizer chain; only its last stage is ever observed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], a_ack};
      end
   end

   // Next-state decode; req only rises after setup with the previous ack fully returned low.
   always_comb begin
      state_s  = state_r;
      a_req_s  = a_req_r;
      a_data_s = a_data_r;
      cnt_s    = cnt_r;
      case (state_r)
         IDLE: begin
            if (s_valid) begin
               a_data_s = s_data;
               cnt_s    = SETUP_V;
               state_s  = SETUP;
            end else begin
               state_s  = IDLE;
            end
         end
         SETUP: begin
            if (cnt_r != '0) begin
               cnt_s = cnt_r - CNT_ONE;
            end else if (!ack_sync_s) begin
               a_req_s = 1'b1;
               state_s = REQ_HI;
            end else begin
               a_req_s = 1'b0;
            end
         end
         REQ_HI: begin
            if (ack_sync_s) begin
               a_req_s = 1'b0;
               state_s = REQ_LO;
            end else begin
               a_req_s = 1'b1;
            end
         end
         REQ_LO: begin
            if (!ack_sync_s) begin
               state_s = IDLE;
            end else begin
               state_s = REQ_LO;
            end
         end
         default: begin
            state_s = IDLE;
            a_req_s = 1'b0;
         end
      endcase
   end

   // Stall watchdog: count cycles per ack edge, raise a sticky flag once the limit is hit.
   always_comb begin
      wait_s  = (state_r == REQ_HI) || (state_r == REQ_LO);
      enter_s = (state_s != state_r) && ((state_s == REQ_HI) || (state_s == REQ_LO));
      if (enter_s) begin
         wcnt_s = '0;
      end else if (wait_s) begin
         wcnt_s = sat_inc(wcnt_r);
      end else begin
         wcnt_s = wcnt_r;
      end
      set_s = TO_EN && wait_s && !enter_s && (wcnt_r == TO_LAST_V);
      if (set_s) begin
         err_s = 1'b1;
      end else if (err_clr) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end
   end

   // State and datapath registers; reset drops a_req without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         a_req_r  <= 1'b0;
         a_data_r <= '0;
         cnt_r    <= '0;
         wcnt_r   <= '0;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         a_req_r  <= a_req_s;
         a_data_r <= a_data_s;
         cnt_r    <= cnt_s;
         wcnt_r   <= wcnt_s;
         err_r    <= err_s;
      end
   end

endmodule
